// File: rtl/snn_conv_pkg.sv
// Shared types and sizing helpers for the event-driven convolution front end.
//   state_t    : control FSM states of conv_evt_gen
//   tap_count  : number of kernel taps for a square kernel edge
//   addr_width : bit width needed to address one axis of a frame
package snn_conv_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SCAN,
    S_EMIT,
    S_ICDONE,
    S_ACTIV,
    S_WAIT,
    S_DONE
  } state_t;

  function automatic int tap_count(input int k);
    return k * k;
  endfunction

  function automatic int addr_width(input int w);
    return (w <= 1) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/spk_prio_enc.sv
// Combinational lowest-set-bit encoder.
//   vec   : input bit vector
//   index : position of the lowest set bit (0 when none)
//   any   : high when at least one bit is set
module spk_prio_enc #(
  parameter int N  = 784,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  vec,
  output logic [IW-1:0] index,
  output logic          any
);

  // Scan from the top down so the last hit is the lowest index.
  always_comb begin
    index = '0;
    any   = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) begin
        index = IW'(i);
        any   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/conv_evt_gen.sv
// Event generator for a spiking convolution layer. For each input channel
// it takes one spike frame, walks the set bits lowest first and, per spike,
// walks the kernel taps, presenting the affected output neuron address.
// After all channels it fires activation and waits for the neuron core to
// sweep the output frame before reporting done.
//
// Ports:
//   clk, rst            : clock, async active-high reset
//   start, last_ts_in   : begin a time step (IDLE only); final-step flag
//   spk_valid/spk_ready : frame handshake; spk_frame bit = y*W+x
//   en_accum, en_activ, ic_done, done : single-cycle pulses
//   ic, filter_phase    : current channel, tap index ky*K+kx
//   affect_neur_addr_y/x, neur_addr_invalid : target neuron, invalid flag
//   last_time_step, busy
//
// Build option CONV_EVT_SKIP_INVALID_EN: when defined, EMIT visits only
// in-bounds taps; otherwise every tap takes a cycle.
module conv_evt_gen
  import snn_conv_pkg::*;
#(
  parameter int IN_CHANNELS        = 2,
  parameter int KERNEL_SIZE        = 3,
  parameter int INPUT_FRAME_WIDTH  = 28,
  parameter int OUTPUT_FRAME_WIDTH = 26
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic last_ts_in,
  input  logic spk_valid,
  output logic spk_ready,
  input  logic [INPUT_FRAME_WIDTH*INPUT_FRAME_WIDTH-1:0] spk_frame,
  output logic en_accum,
  output logic en_activ,
  output logic ic_done,
  output logic [$clog2(IN_CHANNELS)+1:0] ic,
  output logic [$clog2(KERNEL_SIZE)+1:0] filter_phase,
  output logic [$clog2(INPUT_FRAME_WIDTH)-1:0] affect_neur_addr_y,
  output logic [$clog2(INPUT_FRAME_WIDTH)-1:0] affect_neur_addr_x,
  output logic neur_addr_invalid,
  output logic last_time_step,
  output logic busy,
  output logic done
);

  localparam int TAPS      = tap_count(KERNEL_SIZE);
  localparam int AW        = addr_width(INPUT_FRAME_WIDTH);
  localparam int FB        = INPUT_FRAME_WIDTH * INPUT_FRAME_WIDTH;
  localparam int IW        = $clog2(FB);
  localparam int ICW       = $clog2(IN_CHANNELS) + 2;
  localparam int PW        = $clog2(KERNEL_SIZE) + 2;
  localparam int WAIT_LOAD = OUTPUT_FRAME_WIDTH * OUTPUT_FRAME_WIDTH + 1;
  localparam int CW        = $clog2(WAIT_LOAD + 1);

  // Target of tap t for spike (y,x) is (y-ky, x-kx). The extra MSB of the
  // difference is the borrow, so a wrapped coordinate is always rejected.
  function automatic logic tap_ok(input logic [AW-1:0] y, input logic [AW-1:0] x,
                                  input logic [PW-1:0] t);
    logic [PW-1:0] tky, tkx;
    logic [AW:0]   ty, tx;
    tky = t / PW'(KERNEL_SIZE);
    tkx = t % PW'(KERNEL_SIZE);
    ty  = {1'b0, y} - (AW+1)'(tky);
    tx  = {1'b0, x} - (AW+1)'(tkx);
    return !ty[AW] && !tx[AW] &&
           (ty[AW-1:0] <= AW'(OUTPUT_FRAME_WIDTH - 1)) &&
           (tx[AW-1:0] <= AW'(OUTPUT_FRAME_WIDTH - 1));
  endfunction

`ifdef CONV_EVT_SKIP_INVALID_EN
  // {found, tap}: first in-bounds tap at or after 'from'.
  function automatic logic [PW:0] first_ok(input logic [AW-1:0] y, input logic [AW-1:0] x,
                                           input logic [PW-1:0] from);
    logic [PW:0] r;
    r = '0;
    for (int t = TAPS - 1; t >= 0; t--) begin
      if (PW'(t) >= from && tap_ok(y, x, PW'(t))) r = {1'b1, PW'(t)};
    end
    return r;
  endfunction
`endif

  state_t          state, state_n;
  logic [ICW-1:0]  ic_q, ic_n;
  logic [PW-1:0]   phase_q, phase_n;
  logic [FB-1:0]   pend_q, pend_n;
  logic [AW-1:0]   sy_q, sy_n, sx_q, sx_n;
  logic [CW-1:0]   cnt_q, cnt_n;
  logic            lts_q, lts_n;
  logic [AW-1:0]   ay_q, ax_q;

  logic [IW-1:0]   enc_idx;
  logic            enc_any;
  logic [AW-1:0]   scan_y, scan_x;
  logic [PW-1:0]   ky, kx;
  logic [AW:0]     dy, dx;
  logic            tap_valid;

  spk_prio_enc #(.N(FB), .IW(IW)) u_enc (
    .vec   (pend_q),
    .index (enc_idx),
    .any   (enc_any)
  );

  assign scan_y    = AW'(enc_idx / IW'(INPUT_FRAME_WIDTH));
  assign scan_x    = AW'(enc_idx % IW'(INPUT_FRAME_WIDTH));
  assign ky        = phase_q / PW'(KERNEL_SIZE);
  assign kx        = phase_q % PW'(KERNEL_SIZE);
  assign dy        = {1'b0, sy_q} - (AW+1)'(ky);
  assign dx        = {1'b0, sx_q} - (AW+1)'(kx);
  assign tap_valid = (state == S_EMIT) && tap_ok(sy_q, sx_q, phase_q);

  always_comb begin
    state_n = state;
    ic_n    = ic_q;
    phase_n = phase_q;
    pend_n  = pend_q;
    sy_n    = sy_q;
    sx_n    = sx_q;
    cnt_n   = cnt_q;
    lts_n   = lts_q;
    case (state)
      S_IDLE: if (start) begin
        ic_n    = '0;
        lts_n   = last_ts_in;
        state_n = S_LOAD;
      end
      S_LOAD: if (spk_valid) begin
        pend_n  = spk_frame;
        state_n = S_SCAN;
      end
      S_SCAN: if (enc_any) begin
        pend_n[enc_idx] = 1'b0;
        sy_n    = scan_y;
        sx_n    = scan_x;
`ifdef CONV_EVT_SKIP_INVALID_EN
        // Every in-frame spike has at least one in-bounds tap.
        phase_n = first_ok(scan_y, scan_x, '0)[PW-1:0];
`else
        phase_n = '0;
`endif
        state_n = S_EMIT;
      end else begin
        state_n = S_ICDONE;
      end
      S_EMIT: begin
`ifdef CONV_EVT_SKIP_INVALID_EN
        logic [PW:0] nxt;
        nxt = first_ok(sy_q, sx_q, phase_q + PW'(1));
        if (nxt[PW]) phase_n = nxt[PW-1:0];
        else begin
          phase_n = '0;
          state_n = S_SCAN;
        end
`else
        if (phase_q == PW'(TAPS - 1)) begin
          phase_n = '0;
          state_n = S_SCAN;
        end else begin
          phase_n = phase_q + PW'(1);
        end
`endif
      end
      S_ICDONE: if (ic_q == ICW'(IN_CHANNELS - 1)) state_n = S_ACTIV;
      else begin
        ic_n    = ic_q + ICW'(1);
        state_n = S_LOAD;
      end
      S_ACTIV: begin
        cnt_n   = CW'(WAIT_LOAD);
        state_n = S_WAIT;
      end
      // Leave when the decremented count reaches zero, so DONE lands
      // WAIT_LOAD+1 cycles after ACTIV.
      S_WAIT: if (cnt_q <= CW'(1)) begin
        cnt_n   = '0;
        state_n = S_DONE;
      end else begin
        cnt_n = cnt_q - CW'(1);
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      ic_q    <= '0;
      phase_q <= '0;
      pend_q  <= '0;
      sy_q    <= '0;
      sx_q    <= '0;
      cnt_q   <= '0;
      lts_q   <= 1'b0;
      ay_q    <= '0;
      ax_q    <= '0;
    end else begin
      state   <= state_n;
      ic_q    <= ic_n;
      phase_q <= phase_n;
      pend_q  <= pend_n;
      sy_q    <= sy_n;
      sx_q    <= sx_n;
      cnt_q   <= cnt_n;
      lts_q   <= lts_n;
      if (tap_valid) begin
        ay_q <= dy[AW-1:0];
        ax_q <= dx[AW-1:0];
      end
    end
  end

  // Address outputs only ever change to an in-bounds target; otherwise
  // they keep the last valid one.
  assign affect_neur_addr_y = tap_valid ? dy[AW-1:0] : ay_q;
  assign affect_neur_addr_x = tap_valid ? dx[AW-1:0] : ax_q;
  assign neur_addr_invalid  = !tap_valid;
  assign filter_phase       = phase_q;
  assign ic                 = ic_q;
  assign last_time_step     = lts_q;
  assign spk_ready          = (state == S_LOAD);
  assign en_accum           = (state == S_IDLE) && start;
  assign ic_done            = (state == S_ICDONE);
  assign en_activ           = (state == S_ACTIV);
  assign done               = (state == S_DONE);
  assign busy               = (state != S_IDLE);

endmodule
